lif_spike_rate_meter: RTL

//  Downstream consumer of the LIF network spike bus. Counts rising edges per spike channel

---
 rtl/lif_spike_rate_meter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/lif_spike_rate_meter.sv
// lif_spike_rate_meter: counts spike rising edges per channel over a window of enabled cycles
// and snapshots per-channel rates plus their total. Optional alarm comparator: RATE_ALARM_EN.
module lif_spike_rate_meter #(
    parameter  int N_CH  = 8,
    parameter  int CNT_W = 8,
    parameter  int WIN_W = 10,
    localparam int SEL_W = $clog2(N_CH),
    localparam int TOT_W = CNT_W + SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [N_CH-1:0]  spike_in,
    input  logic [WIN_W-1:0] win_len,
    input  logic [SEL_W-1:0] rate_sel,
    output logic [CNT_W-1:0] rate_out,
    output logic [TOT_W-1:0] total_out,
    output logic             rate_valid,
    input  logic [CNT_W-1:0] alarm_thr,
    output logic             alarm
);

    logic [N_CH-1:0]  prev_q, prev_d;
    logic [N_CH-1:0]  rise;
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic [CNT_W-1:0] cnt_inc [N_CH];
    logic [CNT_W-1:0] snap_q  [N_CH];
    logic [CNT_W-1:0] snap_d  [N_CH];
    logic [WIN_W-1:0] wcnt_q, wcnt_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [TOT_W-1:0] total_q, total_d;
    logic             valid_q, valid_d;
    logic             close;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic r);
        if (r && (c != {CNT_W{1'b1}})) begin
            return c + CNT_W'(1);
        end
        return c;
    endfunction

    assign rise  = spike_in & ~prev_q;
    assign close = ena && (wcnt_q == win_q);

    // A rise on the closing cycle is folded into the snapshot rather than the next window.
    always_comb begin
        prev_d  = spike_in;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        wcnt_d  = wcnt_q;
        win_d   = win_q;
        total_d = total_q;
        valid_d = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_inc[i] = sat_add(cnt_q[i], rise[i]);
        end
        if (close) begin
            total_d = '0;
            for (int i = 0; i < N_CH; i++) begin
                snap_d[i] = cnt_inc[i];
                cnt_d[i]  = '0;
                total_d   = total_d + TOT_W'(cnt_inc[i]);
            end
            wcnt_d  = '0;
            win_d   = win_len;
            valid_d = 1'b1;
        end else if (ena) begin
            cnt_d  = cnt_inc;
            wcnt_d = wcnt_q + WIN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= '0;
            wcnt_q  <= '0;
            win_q   <= win_len;
            total_q <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]  <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            prev_q  <= prev_d;
            wcnt_q  <= wcnt_d;
            win_q   <= win_d;
            total_q <= total_d;
            valid_q <= valid_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                snap_q[i] <= snap_d[i];
            end
        end
    end

    // Out-of-range selects fall through to zero.
    always_comb begin
        rate_out = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(rate_sel) == i) begin
                rate_out = snap_q[i];
            end
        end
    end

    assign total_out  = total_q;
    assign rate_valid = valid_q;

`ifdef RATE_ALARM_EN
    logic alarm_q, alarm_d, alarm_hit;

    always_comb begin
        alarm_hit = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (cnt_inc[i] >= alarm_thr) begin
                alarm_hit = 1'b1;
            end
        end
        alarm_d = close ? alarm_hit : alarm_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`else
    logic unused_alarm_thr;
    assign unused_alarm_thr = ^alarm_thr;
    assign alarm = 1'b0;
`endif

endmodule
